icache_boot_ctrl: RTL and testbench

//  Boot loader sequencer for the 256x32 instruction cache. Accepts a valid/ready word stream,

---
 rtl/icache_boot_pkg.sv | 15 +
 rtl/icache_boot_csum.sv | 22 ++
 rtl/icache_boot_ctrl.sv | 158 +++++++++++++++
 tb/tb_icache_boot_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_boot_pkg.sv
// Shared types and sizes for the Icache boot loader.
// Holds the sequencer state encoding and the Icache geometry.
package icache_boot_pkg;

   localparam int ICACHE_ADDR_WIDTH = 8;
   localparam int ICACHE_DEPTH      = 256;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      RUN   = 2'd3
   } boot_state_e;

endpackage

// File: rtl/icache_boot_csum.sv
// Running 32-bit wrap-around sum of the boot words.
// Ports: clk, rst, clear (zero the sum), add_en, data -> sum.
module icache_boot_csum (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        add_en,
   input  logic [31:0] data,
   output logic [31:0] sum
);

   always_ff @(posedge clk) begin
      if (rst) begin
         sum <= '0;
      end else if (clear) begin
         sum <= '0;
      end else if (add_en) begin
         sum <= sum + data;
      end
   end

endmodule

// File: rtl/icache_boot_ctrl.sv
// Boot sequencer: streams words into Icache addr 0..N-1, then hands
// the address mux to the PC (pc_running). Ports: clk, rst, start,
// boot_len, in_valid/in_data/in_ready, reload, exp_csum, ic_wen,
// ic_boot_addr, ic_wdata, pc_running, busy, done, csum_err.
// Optional checksum check: define ICACHE_BOOT_CSUM_EN.
module icache_boot_ctrl
   import icache_boot_pkg::*;
#(
   parameter int ADDR_WIDTH = ICACHE_ADDR_WIDTH,
   parameter int ADDR_NUM   = ICACHE_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   boot_len,
   input  logic                  in_valid,
   input  logic [31:0]           in_data,
   output logic                  in_ready,
   input  logic                  reload,
   input  logic [31:0]           exp_csum,
   output logic                  ic_wen,
   output logic [ADDR_WIDTH-1:0] ic_boot_addr,
   output logic [31:0]           ic_wdata,
   output logic                  pc_running,
   output logic                  busy,
   output logic                  done,
   output logic                  csum_err
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] LEN_MAX = CW'(ADDR_NUM);
   localparam logic [CW-1:0] ONE     = CW'(1);

   boot_state_e state, state_n;

   logic [CW-1:0]         cnt;
   logic [CW-1:0]         len_q;
   logic [CW-1:0]         len_c;
   logic                  accept;
   logic                  last;
   logic                  go;
   logic                  wen_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic                  run_q;
   logic                  done_q;

   assign len_c  = (boot_len > LEN_MAX) ? LEN_MAX : boot_len;
   assign accept = in_valid & in_ready;
   assign last   = accept & (cnt == len_q - ONE);
   assign go     = (state == IDLE) & start;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n  = state;
      in_ready = 1'b0;
      busy     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = (len_c == '0) ? RUN : LOAD;
            end
         end
         LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (last) begin
               state_n = DRAIN;
            end
         end
         // One cycle so the final write lands before the PC owns the mux.
         DRAIN: begin
            busy    = 1'b1;
            state_n = RUN;
         end
         RUN: begin
            if (reload) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         len_q   <= '0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         run_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         wen_q  <= accept;
         run_q  <= (state_n == RUN);
         done_q <= (state_n == RUN) && (state != RUN);
         if (go) begin
            cnt   <= '0;
            len_q <= len_c;
         end else if (accept) begin
            cnt <= cnt + ONE;
         end
         if (accept) begin
            addr_q  <= cnt[ADDR_WIDTH-1:0];
            wdata_q <= in_data;
         end
      end
   end

   assign ic_wen       = wen_q;
   assign ic_boot_addr = addr_q;
   assign ic_wdata     = wdata_q;
   assign pc_running   = run_q;
   assign done         = done_q;

`ifdef ICACHE_BOOT_CSUM_EN
   logic [31:0] sum;
   logic [31:0] exp_q;
   logic        err_q;

   icache_boot_csum u_csum (
      .clk    (clk),
      .rst    (rst),
      .clear  (go),
      .add_en (accept),
      .data   (in_data),
      .sum    (sum)
   );

   // A zero-length load enters RUN on the start edge with an empty sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         exp_q <= '0;
         err_q <= 1'b0;
      end else if (go) begin
         exp_q <= exp_csum;
         err_q <= (len_c == '0) ? (exp_csum != '0) : 1'b0;
      end else if (state == DRAIN) begin
         err_q <= (sum != exp_q);
      end
   end

   assign csum_err = err_q;
`else
   logic csum_unused;
   assign csum_unused = ^exp_csum;
   assign csum_err    = 1'b0;
`endif

endmodule

// File: tb/tb_icache_boot_ctrl.sv
// Bench for icache_boot_ctrl: directed loads with random words and gaps.
// Expected writes/checksum come from a word-list model of the load.
module tb_icache_boot_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [8:0]  boot_len;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        reload;
   logic [31:0] exp_csum;
   logic        ic_wen;
   logic [7:0]  ic_boot_addr;
   logic [31:0] ic_wdata;
   logic        pc_running;
   logic        busy;
   logic        done;
   logic        csum_err;

   icache_boot_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .boot_len     (boot_len),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .reload       (reload),
      .exp_csum     (exp_csum),
      .ic_wen       (ic_wen),
      .ic_boot_addr (ic_boot_addr),
      .ic_wdata     (ic_wdata),
      .pc_running   (pc_running),
      .busy         (busy),
      .done         (done),
      .csum_err     (csum_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0]  obs_a[$];
   logic [31:0] obs_d[$];
   logic [31:0] words[$];
   int          done_cnt;
   int          first_wen_cyc;
   int          last_wen_cyc;
   int          rise_cyc;
   int          overlap;
   logic        pc_prev = 1'b0;

   always @(negedge clk) begin
      if (ic_wen === 1'b1) begin
         if (obs_a.size() == 0) first_wen_cyc = cyc;
         obs_a.push_back(ic_boot_addr);
         obs_d.push_back(ic_wdata);
         last_wen_cyc = cyc;
         if (pc_running !== 1'b0) overlap++;
      end
      if (done === 1'b1) done_cnt++;
      if (pc_running === 1'b1 && pc_prev !== 1'b1) rise_cyc = cyc;
      pc_prev = pc_running;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      n_chk++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic clear_mon();
      obs_a.delete();
      obs_d.delete();
      done_cnt      = 0;
      first_wen_cyc = -1;
      last_wen_cyc  = -1;
      rise_cyc      = -1;
      overlap       = 0;
   endtask

   task automatic do_start(input int len, input logic [31:0] ecs);
      @(negedge clk);
      start    = 1'b1;
      boot_len = 9'(len);
      exp_csum = ecs;
      @(posedge clk);
      #1;
      start = 1'b0;
      clear_mon();
   endtask

   task automatic do_reload();
      @(negedge clk);
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
   endtask

   task automatic fill_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   task automatic feed(input int n, input int gap_max,
                       input int gap_at, input int gap_len);
      int g;
      int t;
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) g = gap_len;
         else if (gap_max > 0) g = $urandom_range(0, gap_max);
         else g = 0;
         repeat (g) begin
            @(negedge clk);
            in_valid = 1'b0;
         end
         if (i == gap_at) begin
            chk("gap_in_ready", in_ready, 1);
            chk("gap_busy", busy, 1);
         end
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = words[i];
         t = 0;
         while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
         end
         if (t >= 20) begin
            chk("accept_timeout", 0, 1);
            break;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_load(input string tag, input int len_req,
                           input int gap_max, input int gap_at,
                           input int gap_len, input logic [31:0] ecs);
      int          n;
      int          bad;
      logic [31:0] sum;
      logic        err_exp;
      n = (len_req > 256) ? 256 : len_req;
      sum = '0;
      for (int i = 0; i < n; i++) sum = sum + words[i];
`ifdef ICACHE_BOOT_CSUM_EN
      err_exp = (sum != ecs);
`else
      err_exp = 1'b0;
`endif
      do_start(len_req, ecs);
      feed(n, gap_max, gap_at, gap_len);
      repeat (3) @(negedge clk);
      bad = 0;
      for (int i = 0; i < obs_a.size() && i < n; i++) begin
         if (obs_a[i] !== 8'(i) || obs_d[i] !== words[i]) bad++;
      end
      chk({tag, "_nwrites"}, obs_a.size(), n);
      chk({tag, "_wr_bad"}, bad, 0);
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_pc_rise"}, rise_cyc, last_wen_cyc + 1);
      chk({tag, "_pc_run"}, pc_running, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_overlap"}, overlap, 0);
      chk({tag, "_csum_err"}, csum_err, err_exp);
      if (gap_max == 0 && gap_at < 0) begin
         chk({tag, "_b2b"}, last_wen_cyc - first_wen_cyc, n - 1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      boot_len = '0;
      in_valid = 1'b0;
      in_data  = '0;
      reload   = 1'b0;
      exp_csum = '0;
      clear_mon();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_wen", ic_wen, 0);
      chk("rst_addr", ic_boot_addr, 0);
      chk("rst_wdata", ic_wdata, 0);
      chk("rst_pc", pc_running, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_csum", csum_err, 0);
      chk("rst_ready", in_ready, 0);
      rst = 1'b0;

      words.delete();
      words.push_back(32'h11);
      words.push_back(32'h22);
      words.push_back(32'h33);
      words.push_back(32'h44);
      run_load("t1", 4, 0, -1, 0, 32'haa);
      do_reload();

      fill_words(3);
      run_load("t2", 3, 0, 0, 5, 32'h0);
      do_reload();

      do_start(0, 32'h5);
      @(negedge clk);
      chk("t3z_done", done, 1);
      chk("t3z_pc", pc_running, 1);
      chk("t3z_wen", ic_wen, 0);
      chk("t3z_busy", busy, 0);
`ifdef ICACHE_BOOT_CSUM_EN
      chk("t3z_csum", csum_err, 1);
`else
      chk("t3z_csum", csum_err, 0);
`endif
      repeat (2) @(negedge clk);
      chk("t3z_done_cnt", done_cnt, 1);
      chk("t3z_nwrites", obs_a.size(), 0);
      do_reload();

      fill_words(256);
      run_load("t3c", 300, 0, -1, 0, 32'h0);
      chk("t3c_last_addr", obs_a[obs_a.size() - 1], 8'hff);
      do_reload();

      fill_words(8);
      do_start(8, 32'h0);
      feed(2, 0, -1, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t4_wen", ic_wen, 0);
      chk("t4_pc", pc_running, 0);
      chk("t4_ready", in_ready, 0);
      chk("t4_busy", busy, 0);
      rst = 1'b0;
      fill_words(2);
      run_load("t4b", 2, 0, -1, 0, 32'h0);

      @(negedge clk);
      reload   = 1'b1;
      start    = 1'b1;
      boot_len = 9'd2;
      @(posedge clk);
      #1;
      reload = 1'b0;
      start  = 1'b0;
      @(negedge clk);
      chk("t5_pc", pc_running, 0);
      chk("t5_ready", in_ready, 0);
      chk("t5_busy", busy, 0);
      fill_words(2);
      run_load("t5b", 2, 0, -1, 0, 32'h0);
      do_reload();

      for (int k = 0; k < 4; k++) begin
         int len;
         len = $urandom_range(1, 16);
         fill_words(len);
         run_load("rnd", len, 3, -1, 0, $urandom);
         do_reload();
      end

`ifdef ICACHE_BOOT_CSUM_EN
      words.delete();
      words.push_back(32'd1);
      words.push_back(32'd2);
      words.push_back(32'd3);
      run_load("t6a", 3, 0, -1, 0, 32'd6);
      do_reload();
      run_load("t6b", 3, 0, -1, 0, 32'd7);
      do_reload();
      @(negedge clk);
      chk("t6_hold", csum_err, 1);
      do_start(3, 32'd6);
      @(negedge clk);
      chk("t6_clr", csum_err, 0);
      feed(3, 0, -1, 0);
      repeat (3) @(negedge clk);
      chk("t6_final", csum_err, 0);
      do_reload();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
